// File: rtl/store_pack_buffer_if.sv
// Store-side bus bundle: MEM-stage store request handshake plus data-memory write port.
// The buffer takes the slave modport; the store issuer / memory side takes master.
interface store_pack_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    modport master (
        output st_valid, st_addr, st_size, st_data, mem_ready,
        input  st_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  st_valid, st_addr, st_size, st_data, mem_ready,
        output st_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_pack_buffer.sv
// Packs byte/half/word stores into word-aligned writes with byte enables and queues them in a FIFO.
// Define STORE_ALIGN_CHECK_EN to reject misaligned half/word stores with a misalign_err pulse.
module store_pack_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    store_pack_buffer_if.slave   bus,
    output logic                 misalign_err,
    output logic                 empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    entry_t pack;
    entry_t head;
    logic   legal;
    logic   push;
    logic   pop;
    logic   enq;

    always_comb begin
        pack       = '0;
        pack.waddr = bus.st_addr[31:2];
        legal      = 1'b1;
        case (bus.st_size)
            2'd0: begin
                pack.wdata = {4{bus.st_data[7:0]}};
                pack.be    = 4'b0001 << bus.st_addr[1:0];
            end
            2'd1: begin
                pack.wdata = {2{bus.st_data[15:0]}};
                pack.be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                pack.wdata = bus.st_data;
                pack.be    = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    assign bus.st_ready = (count_q != FULL_CNT);
    assign push         = bus.st_valid && bus.st_ready;
    assign pop          = bus.mem_valid && bus.mem_ready;

`ifdef STORE_ALIGN_CHECK_EN
    logic misal;
    logic misalign_err_q, misalign_err_d;

    always_comb begin
        misal = 1'b0;
        if (bus.st_size == 2'd1)
            misal = bus.st_addr[0];
        else if (bus.st_size == 2'd2)
            misal = (bus.st_addr[1:0] != 2'b00);
    end

    assign enq            = push && legal && !misal;
    assign misalign_err_d = push && (!legal || misal);

    always_ff @(posedge clk) begin
        if (!reset) misalign_err_q <= 1'b0;
        else        misalign_err_q <= misalign_err_d;
    end

    assign misalign_err = misalign_err_q;
`else
    assign enq          = push && legal;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            fifo_d[wr_ptr_q] = pack;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({enq, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign head          = fifo_q[rd_ptr_q];
    assign bus.mem_valid = (count_q != '0);
    assign empty         = (count_q == '0);
    assign bus.mem_addr  = bus.mem_valid ? {head.waddr, 2'b00} : 32'h0;
    assign bus.mem_wdata = bus.mem_valid ? head.wdata : 32'h0;
    assign bus.mem_be    = bus.mem_valid ? head.be : 4'h0;
endmodule

// File: tb/tb_store_pack_buffer.sv
// Self-checking bench for store_pack_buffer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_store_pack_buffer;
    localparam int DEPTH = 2;

    logic clk;
    logic reset;
    logic misalign_err;
    logic empty;

    store_pack_buffer_if bus ();

    store_pack_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .misalign_err (misalign_err),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    logic exp_err;
    bit   chk_en;
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: what memory must see, derived from the store rules.
    always @(posedge clk) begin
        if (!reset) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            bit          do_push, do_pop, ok, mis;
            exp_t        e;
            logic [31:0] a;
            a       = bus.st_addr;
            do_push = bus.st_valid && (exp_q.size() != DEPTH);
            do_pop  = (exp_q.size() != 0) && bus.mem_ready;
            e.addr  = a - (a % 4);
            ok      = 1'b1;
            mis     = 1'b0;
            case (bus.st_size)
                2'd0: begin
                    e.wdata = 32'(bus.st_data[7:0]) * 32'h0101_0101;
                    e.be    = 4'(1 << (a % 4));
                end
                2'd1: begin
                    e.wdata = 32'(bus.st_data[15:0]) * 32'h0001_0001;
                    e.be    = ((a % 4) >= 2) ? 4'd12 : 4'd3;
                    mis     = (a % 2) != 0;
                end
                2'd2: begin
                    e.wdata = bus.st_data;
                    e.be    = 4'd15;
                    mis     = (a % 4) != 0;
                end
                default: begin
                    e.wdata = 32'h0;
                    e.be    = 4'd0;
                    ok      = 1'b0;
                end
            endcase
`ifndef STORE_ALIGN_CHECK_EN
            mis = 1'b0;
`endif
            if (do_pop) void'(exp_q.pop_front());
            if (do_push && ok && !mis) exp_q.push_back(e);
`ifdef STORE_ALIGN_CHECK_EN
            exp_err = do_push && (!ok || mis);
`else
            exp_err = 1'b0;
`endif
        end
    end

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_valid", 32'(bus.mem_valid), 32'(exp_q.size() != 0));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0));
            chk("st_ready", 32'(bus.st_ready), 32'(exp_q.size() != DEPTH));
            chk("misalign_err", 32'(misalign_err), 32'(exp_err));
            if (exp_q.size() != 0) begin
                chk("mem_addr", bus.mem_addr, exp_q[0].addr);
                chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                chk("mem_be", 32'(bus.mem_be), 32'(exp_q[0].be));
            end else begin
                chk("mem_addr_idle", bus.mem_addr, 32'h0);
                chk("mem_wdata_idle", bus.mem_wdata, 32'h0);
                chk("mem_be_idle", 32'(bus.mem_be), 32'h0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic mr);
        @(negedge clk);
        #1;
        bus.st_valid  = v;
        bus.st_addr   = a;
        bus.st_size   = s;
        bus.st_data   = d;
        bus.mem_ready = mr;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic mr, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 2'd0, 32'h0, mr);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        reset  = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = 32'h0;
        bus.st_size   = 2'd0;
        bus.st_data   = 32'h0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        chk("reset_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("reset_st_ready", 32'(bus.st_ready), 32'h1);
        chk("reset_empty", 32'(empty), 32'h1);

        // Byte pack into lane 3.
        cyc(1'b1, 32'h0000_1003, 2'd0, 32'h0000_00AB, 1'b1);
        after_edge();
        chk("byte_valid", 32'(bus.mem_valid), 32'h1);
        chk("byte_addr", bus.mem_addr, 32'h0000_1000);
        chk("byte_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        chk("byte_be", 32'(bus.mem_be), 32'h8);
        chk("model_byte_wdata", exp_q[0].wdata, 32'hABAB_ABAB);
        idle(1'b1, 2);

        // Halfword held under backpressure for 3 cycles.
        cyc(1'b1, 32'h0000_2002, 2'd1, 32'h0000_1234, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc(1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
            after_edge();
            chk("half_addr", bus.mem_addr, 32'h0000_2000);
            chk("half_wdata", bus.mem_wdata, 32'h1234_1234);
            chk("half_be", 32'(bus.mem_be), 32'hC);
        end
        chk("model_half_be", 32'(exp_q[0].be), 32'hC);
        cyc(1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
        after_edge();
        chk("half_popped_empty", 32'(empty), 32'h1);

        // Fill, refuse, drain in order with pointer wrap.
        cyc(1'b1, 32'h10, 2'd2, 32'h1111_0010, 1'b0);
        cyc(1'b1, 32'h14, 2'd2, 32'h2222_0014, 1'b0);
        after_edge();
        chk("full_st_ready", 32'(bus.st_ready), 32'h0);
        cyc(1'b1, 32'h18, 2'd2, 32'h3333_0018, 1'b0);
        after_edge();
        chk("full_head_held", bus.mem_addr, 32'h10);
        cyc(1'b1, 32'h18, 2'd2, 32'h3333_0018, 1'b1);
        after_edge();
        chk("drain_head_14", bus.mem_addr, 32'h14);
        chk("drain_third_refused", 32'(exp_q.size()), 32'd1);
        cyc(1'b1, 32'h18, 2'd2, 32'h3333_0018, 1'b1);
        after_edge();
        chk("drain_head_18", bus.mem_addr, 32'h18);
        chk("drain_wdata_18", bus.mem_wdata, 32'h3333_0018);
        idle(1'b1, 1);
        after_edge();
        chk("drain_empty", 32'(empty), 32'h1);

        // Steady push+pop at count 1.
        cyc(1'b1, 32'h100, 2'd2, 32'hA000_0000, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'h100 + 32'(4 * i), 2'd2, 32'hA000_0000 + 32'(i), 1'b1);
            after_edge();
            chk("stream_st_ready", 32'(bus.st_ready), 32'h1);
            chk("stream_head", bus.mem_addr, 32'h100 + 32'(4 * i));
        end
        idle(1'b1, 2);

        // Misaligned word.
        cyc(1'b1, 32'h0000_3001, 2'd2, 32'hCAFE_F00D, 1'b0);
        after_edge();
`ifdef STORE_ALIGN_CHECK_EN
        chk("misal_no_valid", 32'(bus.mem_valid), 32'h0);
        chk("misal_err", 32'(misalign_err), 32'h1);
        cyc(1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
        after_edge();
        chk("misal_err_cleared", 32'(misalign_err), 32'h0);
`else
        chk("misal_addr", bus.mem_addr, 32'h0000_3000);
        chk("misal_be", 32'(bus.mem_be), 32'hF);
        chk("misal_err_tied", 32'(misalign_err), 32'h0);
`endif
        idle(1'b1, 2);

        // Illegal size: handshake, nothing queued.
        cyc(1'b1, 32'h0000_4000, 2'd3, 32'h1, 1'b0);
        after_edge();
        chk("size3_no_valid", 32'(bus.mem_valid), 32'h0);
        idle(1'b1, 2);

        // Reset mid-drain.
        cyc(1'b1, 32'h50, 2'd2, 32'h5, 1'b0);
        cyc(1'b1, 32'h54, 2'd2, 32'h6, 1'b0);
        cyc(1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
        reset = 1'b0;
        after_edge();
        reset = 1'b1;
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_st_ready", 32'(bus.st_ready), 32'h1);
        idle(1'b1, 4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 255), 24'h0} | ($urandom & 32'h0000_0FFF);
            cyc(1'($urandom_range(0, 3) != 0), a, 2'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 2) != 0));
            reset = ($urandom_range(0, 99) != 0);
        end
        reset = 1'b1;
        idle(1'b1, 4);
        chk("final_empty", 32'(empty), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/store_pack_buffer.md
# store_pack_buffer

Store-side counterpart to the immediate/load extender: it narrows and packs byte/halfword/word store data into word-aligned memory writes with byte enables. It holds a small FIFO of packed stores behind a valid/ready handshake toward data memory, so the MEM stage can issue a store without waiting on memory. It sits between the MEM-stage store path and the data-memory write port.

## Interface
Parameters:
- DEPTH, 2, number of buffered store entries (power of two, ≥2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- st_valid  input  1  store request present
- st_ready  output  1  buffer can accept a request this cycle
- st_addr  input  32  byte address of store
- st_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
- st_data  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- mem_valid  output  1  head entry presented to memory
- mem_ready  input  1  memory accepts head entry this cycle
- mem_addr  output  32  word address: {st_addr[31:2], 2'b00}
- mem_wdata  output  32  packed write data
- mem_be  output  4  byte enables, bit i = byte lane i ([8i+7:8i])
- misalign_err  output  1  one-cycle pulse, rejected store (see Configuration)
- empty  output  1  no buffered entries

## Operation
- Push: st_valid && st_ready. Pop: mem_valid && mem_ready.
- Packing at push:
  - byte: wdata = {4{st_data[7:0]}}, be = 4'b0001 << st_addr[1:0]
  - half: wdata = {2{st_data[15:0]}}, be = st_addr[1] ? 4'b1100 : 4'b0011
  - word: wdata = st_data, be = 4'b1111
  - size 3: handshake completes, nothing enqueued, no memory write.
- FIFO: write/read pointers of log2(DEPTH) bits, wrap modulo DEPTH; count of log2(DEPTH)+1 bits.
- st_ready = (count != DEPTH). No bypass: a full buffer refuses a push even if a pop occurs the same cycle.
- mem_valid = (count != 0); empty = (count == 0).
- Simultaneous push and pop (count > 0, not full): both occur, count unchanged, order preserved.
- When mem_valid = 0, mem_addr, mem_wdata and mem_be are driven to 0.
- Stores drain strictly in push order. There is no merging of entries.

## Timing
- Reset (reset = 0 at a rising edge): count, pointers = 0. Next cycle: mem_valid = 0, mem_addr/mem_wdata/mem_be = 0, st_ready = 1, empty = 1, misalign_err = 0.
- Reset mid-operation discards all entries, including a head entry that mem_ready has not yet accepted. No partial write is reissued.
- Latency: an entry pushed at edge N is visible on mem_valid after edge N (one cycle). Throughput is one store per cycle when mem_ready is held at 1.
- Once asserted, mem_valid and the head fields stay stable until a cycle with mem_ready = 1.
- misalign_err is registered. It is high for exactly the one cycle after the rejected push edge.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - Halfword with st_addr[0] = 1, or word with st_addr[1:0] != 0, is misaligned.
  - A misaligned request completes its handshake (st_ready unaffected), is not enqueued, and pulses misalign_err.
  - Size 3 also pulses misalign_err.
- STORE_ALIGN_CHECK_EN undefined:
  - No check. Halfword ignores st_addr[0]; word ignores st_addr[1:0].
  - Every legal size is enqueued.
  - misalign_err is tied to 0; the port remains present.

## Test plan
- Byte pack: push addr 0x1003, size 0, data 0x000000AB, mem_ready = 1 → next cycle mem_valid = 1, mem_addr 0x1000, mem_wdata 0xABABABAB, mem_be 4'b1000.
- Half pack and backpressure: push addr 0x2002, size 1, data 0x1234 with mem_ready = 0 for 3 cycles → mem_addr 0x2000, mem_wdata 0x12341234, mem_be 4'b1100 held stable all 3 cycles; entry pops on the first mem_ready = 1.
- Full/wrap: DEPTH = 2, mem_ready = 0, push word stores to 0x10, 0x14, 0x18 → st_ready = 0 after second push, third held. Raise mem_ready → drains 0x10, 0x14, 0x18 in order; pointers wrap; empty = 1 at end.
- Simultaneous push/pop: count = 1 with mem_ready = 1 and a new push every cycle for 8 cycles → count stays 1, 8 writes in order, st_ready never drops.
- Misalignment: with macro, word to 0x3001 → no mem_valid, misalign_err = 1 for one cycle. Without macro → mem_addr 0x3000, mem_be 4'b1111, misalign_err = 0.
- Reset mid-drain: 2 entries queued, mem_ready = 0, reset = 0 for one edge → mem_valid = 0, empty = 1, st_ready = 1 the next cycle; no stale entry ever appears.
